hgc_mode_ctrl: RTL and testbench
================================

Name: hgc_mode_ctrl

Overview:
- Parametrised successor to the Hercules register front end: ISA I/O decode, mode-control register, configuration switch, status register, light-pen latch and frame-locked blink generation.
- Sits between the ISA bus and the CRTC/sequencer/pixel path.
- Feeds grph_mode, grph_page, video/blink enables and blink phases to the pixel pipeline, and chip-select to the 6845.
- Adds over the previous generation: multi-page selection, config-switch page clamping, edge-qualified writes, vsync-locked cursor/char blink at separate rates, and a light-pen latch.

Parameters:
- IO_BASE_ADDR, 16'h3B0, I/O base; low nibble must be 0.
- PAGE_BITS, 1, graphics page-select width; legal values 1 or 2.
- CURSOR_FRAMES, 8, vsync periods per cursor_blink toggle; must be ≥1.
- CHAR_FRAMES, 16, vsync periods per char_blink toggle; must be ≥1.

Ports:
- clk  in  1  system clock
- reset_l  in  1  asynchronous, active-low reset
- bus_a  in  15  ISA address
- bus_ior_l  in  1  I/O read strobe, active low
- bus_iow_l  in  1  I/O write strobe, active low
- bus_aen  in  1  DMA address enable; high blocks decode
- bus_d  in  8  ISA write data
- bus_out  out  8  read data
- bus_dir  out  1  high while this block drives a read
- hercules_hw  in  1  global enable for all decodes
- crtc_cs  out  1  decode of base+0..7
- crtc_dout  in  8  CRTC read data
- vsync  in  1  CRTC vsync, active high
- hsync_in  in  1  CRTC hsync, active high
- video  in  1  current pixel value
- lpen_strobe  in  1  light-pen trigger, asynchronous
- grph_mode  out  1  graphics mode
- grph_page  out  PAGE_BITS  displayed graphics page
- video_enabled  out  1  video enable
- blink_enabled  out  1  character blink enable
- hsync  out  1  hsync_in AND video_enabled
- cursor_blink  out  1  cursor blink phase
- char_blink  out  1  character blink phase

Behaviour:
- Decodes are combinational, and all are gated by hercules_hw & ~bus_aen:
  - crtc_cs: bus_a[14:3] == IO_BASE_ADDR[14:3].
  - ctrl: base+8.
  - status: base+A.
  - lpen_clr: base+B.
  - cfg: base+F.
- Write qualification:
  - bus_iow_l is passed through a 2-flop synchroniser, then falling-edge detected.
  - Exactly one write pulse occurs per strobe, one cycle wide, 3 clk after the strobe falls.
  - Address and data are sampled on that pulse.
- cfg register, width 1+PAGE_BITS, reset 0:
  - Write stores bus_d[PAGE_BITS:0].
  - Bit 0 = graphics allowed.
  - Bits [PAGE_BITS:1] = highest permitted page.
- ctrl write, applied on the write pulse:
  - grph_mode <= bus_d[1] & cfg[0].
  - video_enabled <= bus_d[3].
  - blink_enabled <= bus_d[5].
  - req = bus_d[7] when PAGE_BITS=1; {bus_d[7],bus_d[6]} when PAGE_BITS=2.
  - grph_page <= (req > cfg[PAGE_BITS:1]) ? 0 : req.
  - The comparison is unsigned.
- Clamping is applied only at ctrl write. A later cfg write does not alter the current page or mode.
- Read mux (combinational, priority order; anything else reads 8'h00):
  - status read: {~vsync, 3'b111, video, 1'b0, lpen_latch, hsync_in}.
  - crtc_cs & bus_a[0] read: crtc_dout.
- bus_dir = (status_cs | (crtc_cs & bus_a[0])) & ~bus_ior_l.
- Light pen:
  - lpen_strobe goes through a 2-flop synchroniser; its rising edge sets lpen_latch.
  - A write pulse to lpen_clr clears it.
  - If set and clear land in the same cycle, set wins.
- Blink generation:
  - vsync rising edge (registered edge detect) increments two frame counters, each sized $clog2(N+1).
  - When a counter reaches N-1 on an edge, it wraps to 0 and toggles its output, so the output period is 2·N frames.
  - Counters run regardless of blink_enabled.
- Reset values (asynchronous on reset_l low, all outputs):
  - grph_mode 0, grph_page 0, video_enabled 1, blink_enabled 1.
  - cfg 0, lpen_latch 0, cursor_blink 0, char_blink 0.
  - Counters and synchronisers at idle: iow sync = 1, lpen sync = 0, vsync prior = 0.
- A write strobe in flight when reset asserts is discarded. After release, a write pulse fires only on a new falling edge.

Decomposition:
- Package hgc_pkg: register offsets CTRL_OFS=8, STATUS_OFS=A, LPEN_CLR_OFS=B, CFG_OFS=F; CTRL reset constant 8'h28; status constant bits.
- Sub-module hgc_frame_blink, instantiated twice: parameter N, inputs clk/reset_l/vsync_edge, output blink_q.

Test Plan:
- Reset, then read base+A with vsync=1, video=1, hsync_in=1 → 8'h79, bus_dir=1; grph_mode=0, video_enabled=1, blink_enabled=1.
- cfg=8'h03, ctrl write 8'h82 → grph_mode=1, grph_page=1; cfg=8'h00, ctrl 8'h82 → grph_mode=0, grph_page=0.
- PAGE_BITS=2, cfg=8'h05 (max page 2), ctrl 8'hC2 (req 3) → page 0; ctrl 8'h82 (req 2) → page 2.
- iow_l held low 20 clk → exactly one ctrl update, 3 clk after the falling edge.
- CURSOR_FRAMES=8, 16 vsync pulses → cursor_blink toggles at pulses 8 and 16; char_blink toggles at pulse 16 only.
- lpen rising edge → status bit1=1; write base+B → 0; set and clear in the same cycle → stays 1; reset_l low mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/hgc_pkg.sv
// Shared register map, reset constants and offset decode for the Hercules-class mode controller.
package hgc_pkg;

    localparam logic [3:0] CTRL_OFS     = 4'h8;
    localparam logic [3:0] STATUS_OFS   = 4'hA;
    localparam logic [3:0] LPEN_CLR_OFS = 4'hB;
    localparam logic [3:0] CFG_OFS      = 4'hF;

    localparam logic [7:0] CTRL_RST       = 8'h28;
    localparam int         CTRL_GRPH_BIT  = 1;
    localparam int         CTRL_VIDEO_BIT = 3;
    localparam int         CTRL_BLINK_BIT = 5;

    // Bits [6:4] of the status word always read as ones.
    localparam logic [2:0] STATUS_ONES = 3'b111;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_STATUS,
        REG_LPEN_CLR,
        REG_CFG
    } reg_sel_e;

    function automatic reg_sel_e decode_ofs(input logic [3:0] ofs);
        reg_sel_e sel;
        sel = REG_NONE;
        case (ofs)
            CTRL_OFS:     sel = REG_CTRL;
            STATUS_OFS:   sel = REG_STATUS;
            LPEN_CLR_OFS: sel = REG_LPEN_CLR;
            CFG_OFS:      sel = REG_CFG;
            default:      sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hgc_frame_blink.sv
// Frame-locked blink divider: toggles blink_q once every N vsync rising edges.
module hgc_frame_blink
    import hgc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset_l,
    input  logic vsync_edge,
    output logic blink_q
);

    localparam int           W  = $clog2(N + 1);
    localparam logic [W-1:0] TC = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         r_blink;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (vsync_edge) begin
            if (r_cnt == TC) begin
                r_cnt   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign blink_q = r_blink;

endmodule

// File: rtl/hgc_mode_ctrl.sv
// ISA register front end: I/O decode, mode/config registers, status read-back,
// light-pen latch and vsync-locked cursor/character blink.
module hgc_mode_ctrl
    import hgc_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR  = 16'h3B0,
    parameter int          PAGE_BITS     = 1,
    parameter int          CURSOR_FRAMES = 8,
    parameter int          CHAR_FRAMES   = 16
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [14:0]          bus_a,
    input  logic                 bus_ior_l,
    input  logic                 bus_iow_l,
    input  logic                 bus_aen,
    input  logic [7:0]           bus_d,
    output logic [7:0]           bus_out,
    output logic                 bus_dir,
    input  logic                 hercules_hw,
    output logic                 crtc_cs,
    input  logic [7:0]           crtc_dout,
    input  logic                 vsync,
    input  logic                 hsync_in,
    input  logic                 video,
    input  logic                 lpen_strobe,
    output logic                 grph_mode,
    output logic [PAGE_BITS-1:0] grph_page,
    output logic                 video_enabled,
    output logic                 blink_enabled,
    output logic                 hsync,
    output logic                 cursor_blink,
    output logic                 char_blink
);

    logic                 w_dec_en;
    logic                 w_base_hit;
    reg_sel_e             w_reg_sel;
    logic                 w_status_cs;
    logic                 w_crtc_rd;
    logic                 w_wr_pulse;
    logic                 w_wr_ctrl;
    logic                 w_wr_cfg;
    logic                 w_wr_lpen_clr;
    logic [PAGE_BITS-1:0] w_req;
    logic [PAGE_BITS-1:0] w_max_page;
    logic                 w_lpen_rise;
    logic                 w_vsync_edge;
    logic [7:0]           w_status;
    logic                 w_unused;

    logic                 r_iow_s1, r_iow_s2, r_iow_s3;
    logic [1:0]           r_iow_vld;
    logic                 r_iow_armed;
    logic                 r_lpen_s1, r_lpen_s2, r_lpen_s3;
    logic                 r_lpen_latch;
    logic                 r_vsync_q;
    logic [PAGE_BITS:0]   r_cfg;
    logic                 r_grph_mode;
    logic [PAGE_BITS-1:0] r_grph_page;
    logic                 r_video_en;
    logic                 r_blink_en;

    assign w_dec_en   = hercules_hw & ~bus_aen;
    assign w_base_hit = (bus_a[14:4] == IO_BASE_ADDR[14:4]);
    assign crtc_cs    = w_dec_en & (bus_a[14:3] == IO_BASE_ADDR[14:3]);
    assign w_reg_sel  = (w_dec_en & w_base_hit) ? decode_ofs(bus_a[3:0]) : REG_NONE;
    assign w_status_cs = (w_reg_sel == REG_STATUS);
    assign w_crtc_rd   = crtc_cs & bus_a[0];

    // The sync chain resets to "idle high", so a strobe already low at reset
    // release would look like a fresh fall; the write path only arms once
    // the synchronised strobe has genuinely been seen high.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_iow_s1    <= 1'b1;
            r_iow_s2    <= 1'b1;
            r_iow_s3    <= 1'b1;
            r_iow_vld   <= 2'b00;
            r_iow_armed <= 1'b0;
        end else begin
            r_iow_s1    <= bus_iow_l;
            r_iow_s2    <= r_iow_s1;
            r_iow_s3    <= r_iow_s2;
            r_iow_vld   <= {r_iow_vld[0], 1'b1};
            r_iow_armed <= r_iow_armed | (r_iow_vld[1] & r_iow_s2);
        end
    end

    assign w_wr_pulse    = r_iow_armed & r_iow_s3 & ~r_iow_s2;
    assign w_wr_ctrl     = w_wr_pulse & (w_reg_sel == REG_CTRL);
    assign w_wr_cfg      = w_wr_pulse & (w_reg_sel == REG_CFG);
    assign w_wr_lpen_clr = w_wr_pulse & (w_reg_sel == REG_LPEN_CLR);

    assign w_req      = bus_d[7 -: PAGE_BITS];
    assign w_max_page = r_cfg[PAGE_BITS:1];

    // Page clamp is evaluated only here; a later cfg write leaves mode/page alone.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_cfg       <= '0;
            r_grph_mode <= CTRL_RST[CTRL_GRPH_BIT];
            r_grph_page <= '0;
            r_video_en  <= CTRL_RST[CTRL_VIDEO_BIT];
            r_blink_en  <= CTRL_RST[CTRL_BLINK_BIT];
        end else begin
            if (w_wr_cfg) begin
                r_cfg <= bus_d[PAGE_BITS:0];
            end
            if (w_wr_ctrl) begin
                r_grph_mode <= bus_d[CTRL_GRPH_BIT] & r_cfg[0];
                r_grph_page <= (w_req > w_max_page) ? '0 : w_req;
                r_video_en  <= bus_d[CTRL_VIDEO_BIT];
                r_blink_en  <= bus_d[CTRL_BLINK_BIT];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_lpen_s1    <= 1'b0;
            r_lpen_s2    <= 1'b0;
            r_lpen_s3    <= 1'b0;
            r_lpen_latch <= 1'b0;
            r_vsync_q    <= 1'b0;
        end else begin
            r_lpen_s1 <= lpen_strobe;
            r_lpen_s2 <= r_lpen_s1;
            r_lpen_s3 <= r_lpen_s2;
            r_vsync_q <= vsync;
            if (w_lpen_rise) begin
                r_lpen_latch <= 1'b1;
            end else if (w_wr_lpen_clr) begin
                r_lpen_latch <= 1'b0;
            end
        end
    end

    assign w_lpen_rise  = r_lpen_s2 & ~r_lpen_s3;
    assign w_vsync_edge = vsync & ~r_vsync_q;

    hgc_frame_blink #(.N(CURSOR_FRAMES)) u_cursor_blink (
        .clk        (clk),
        .reset_l    (reset_l),
        .vsync_edge (w_vsync_edge),
        .blink_q    (cursor_blink)
    );

    hgc_frame_blink #(.N(CHAR_FRAMES)) u_char_blink (
        .clk        (clk),
        .reset_l    (reset_l),
        .vsync_edge (w_vsync_edge),
        .blink_q    (char_blink)
    );

    assign w_status = {~vsync, STATUS_ONES, video, 1'b0, r_lpen_latch, hsync_in};

    always_comb begin
        bus_out = 8'h00;
        if (w_status_cs) begin
            bus_out = w_status;
        end else if (w_crtc_rd) begin
            bus_out = crtc_dout;
        end
    end

    assign bus_dir = (w_status_cs | w_crtc_rd) & ~bus_ior_l;

    assign grph_mode     = r_grph_mode;
    assign grph_page     = r_grph_page;
    assign video_enabled = r_video_en;
    assign blink_enabled = r_blink_en;
    assign hsync         = hsync_in & r_video_en;

    // Data bits with no register behind them.
    assign w_unused = &{1'b0, bus_d};

endmodule

// File: tb/tb_hgc_mode_ctrl.sv
// Self-checking bench for hgc_mode_ctrl: one-bit and two-bit page instances share the bus.
module tb_hgc_mode_ctrl;

    localparam logic [14:0] BASE = 15'h3B0;

    logic        clk, reset_l;
    logic [14:0] bus_a;
    logic        bus_ior_l, bus_iow_l, bus_aen, hercules_hw;
    logic [7:0]  bus_d, crtc_dout;
    logic        vsync, hsync_in, video, lpen_strobe;

    logic [7:0]  d1_bus_out, d2_bus_out;
    logic        d1_bus_dir, d2_bus_dir, d1_crtc_cs, d2_crtc_cs;
    logic        d1_grph_mode, d2_grph_mode;
    logic [0:0]  d1_grph_page;
    logic [1:0]  d2_grph_page;
    logic        d1_ven, d2_ven, d1_ben, d2_ben, d1_hsync, d2_hsync;
    logic        d1_cur, d2_cur, d1_chr, d2_chr;

    hgc_mode_ctrl #(.PAGE_BITS(1)) u_dut1 (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_ior_l(bus_ior_l),
        .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(d1_bus_out),
        .bus_dir(d1_bus_dir), .hercules_hw(hercules_hw), .crtc_cs(d1_crtc_cs),
        .crtc_dout(crtc_dout), .vsync(vsync), .hsync_in(hsync_in), .video(video),
        .lpen_strobe(lpen_strobe), .grph_mode(d1_grph_mode), .grph_page(d1_grph_page),
        .video_enabled(d1_ven), .blink_enabled(d1_ben), .hsync(d1_hsync),
        .cursor_blink(d1_cur), .char_blink(d1_chr)
    );

    hgc_mode_ctrl #(.PAGE_BITS(2)) u_dut2 (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_ior_l(bus_ior_l),
        .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(d2_bus_out),
        .bus_dir(d2_bus_dir), .hercules_hw(hercules_hw), .crtc_cs(d2_crtc_cs),
        .crtc_dout(crtc_dout), .vsync(vsync), .hsync_in(hsync_in), .video(video),
        .lpen_strobe(lpen_strobe), .grph_mode(d2_grph_mode), .grph_page(d2_grph_page),
        .video_enabled(d2_ven), .blink_enabled(d2_ben), .hsync(d2_hsync),
        .cursor_blink(d2_cur), .char_blink(d2_chr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state, kept as plain integers.
    int m_cfg1, m_cfg2, m_mode1, m_page1, m_mode2, m_page2;
    int m_ven, m_ben, m_lpen, m_edges;

    typedef struct {
        int ofs; int d; int hw; int aen;
        int mode1; int page1; int mode2; int page2; int ven; int ben;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int offset_of(input logic [14:0] a, input logic hw, input logic aen);
        int o;
        o = int'(a) - int'(BASE);
        if (!hw || aen || o < 0 || o > 15) return -1;
        return o;
    endfunction

    task automatic model_write(input logic [14:0] a, input logic [7:0] d,
                               input logic hw, input logic aen);
        int o, req1, req2, max1, max2;
        o = offset_of(a, hw, aen);
        if (o == 8) begin
            req1 = int'(d) / 128;
            req2 = int'(d) / 64;
            max1 = m_cfg1 / 2;
            max2 = m_cfg2 / 2;
            m_mode1 = int'(d[1]) & (m_cfg1 % 2);
            m_mode2 = int'(d[1]) & (m_cfg2 % 2);
            m_page1 = (req1 > max1) ? 0 : req1;
            m_page2 = (req2 > max2) ? 0 : req2;
            m_ven = int'(d[3]);
            m_ben = int'(d[5]);
        end else if (o == 11) begin
            m_lpen = 0;
        end else if (o == 15) begin
            m_cfg1 = int'(d) % 4;
            m_cfg2 = int'(d) % 8;
        end
    endtask

    task automatic check_all();
        chk("grph_mode1", int'(d1_grph_mode), m_mode1);
        chk("grph_page1", int'(d1_grph_page), m_page1);
        chk("grph_mode2", int'(d2_grph_mode), m_mode2);
        chk("grph_page2", int'(d2_grph_page), m_page2);
        chk("video_en1", int'(d1_ven), m_ven);
        chk("video_en2", int'(d2_ven), m_ven);
        chk("blink_en1", int'(d1_ben), m_ben);
        chk("blink_en2", int'(d2_ben), m_ben);
        chk("hsync1", int'(d1_hsync), int'(hsync_in) & m_ven);
        chk("hsync2", int'(d2_hsync), int'(hsync_in) & m_ven);
        chk("cursor1", int'(d1_cur), (m_edges / 8) % 2);
        chk("cursor2", int'(d2_cur), (m_edges / 8) % 2);
        chk("char1", int'(d1_chr), (m_edges / 16) % 2);
        chk("char2", int'(d2_chr), (m_edges / 16) % 2);
    endtask

    // All stimulus tasks are entered and left on (or just after) a falling edge.
    task automatic do_reset();
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        m_cfg1 = 0; m_cfg2 = 0; m_mode1 = 0; m_page1 = 0; m_mode2 = 0; m_page2 = 0;
        m_ven = 1; m_ben = 1; m_lpen = 0;
        m_edges = vsync ? 1 : 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic io_write(input logic [14:0] a, input logic [7:0] d,
                            input logic hw, input logic aen);
        bus_a = a; bus_d = d; hercules_hw = hw; bus_aen = aen;
        bus_iow_l = 1'b0;
        repeat (4) @(negedge clk);
        bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        model_write(a, d, hw, aen);
        hercules_hw = 1'b1; bus_aen = 1'b0;
    endtask

    task automatic set_vsync(input logic v);
        if (v && !vsync) m_edges++;
        vsync = v;
        @(negedge clk);
    endtask

    task automatic check_read(input logic [14:0] a, input logic hw, input logic aen,
                              input logic ior);
        int o, cs, rd, st;
        logic [7:0] exp;
        bus_a = a; hercules_hw = hw; bus_aen = aen; bus_ior_l = ior;
        #1;
        o = offset_of(a, hw, aen);
        cs = (hw && !aen && (int'(a) / 8 == int'(BASE) / 8)) ? 1 : 0;
        st = (o == 10) ? 1 : 0;
        rd = (cs == 1 && a[0]) ? 1 : 0;
        exp = 8'h00;
        if (st == 1) exp = {~vsync, 3'b111, video, 1'b0, (m_lpen != 0), hsync_in};
        else if (rd == 1) exp = crtc_dout;
        chk("bus_out1", int'(d1_bus_out), int'(exp));
        chk("bus_out2", int'(d2_bus_out), int'(exp));
        chk("bus_dir", int'(d1_bus_dir), (st | rd) & int'(!ior));
        chk("crtc_cs", int'(d1_crtc_cs), cs);
        bus_ior_l = 1'b1; hercules_hw = 1'b1; bus_aen = 1'b0;
    endtask

    task automatic status_bit(input string name, input int exp);
        bus_a = BASE + 15'd10; hercules_hw = 1'b1; bus_aen = 1'b0; bus_ior_l = 1'b0;
        #1;
        chk(name, int'(d1_bus_out[1]), exp);
        bus_ior_l = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        int   ofs, op;
        logic [14:0] a;

        vecs[0]  = '{15, 8'h03, 1, 0,  0, 0, 0, 0, 1, 1};
        vecs[1]  = '{8,  8'h82, 1, 0,  1, 1, 1, 0, 0, 0};
        vecs[2]  = '{15, 8'h00, 1, 0,  1, 1, 1, 0, 0, 0};
        vecs[3]  = '{8,  8'h82, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[4]  = '{15, 8'h05, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[5]  = '{8,  8'hC2, 1, 0,  1, 0, 1, 0, 0, 0};
        vecs[6]  = '{8,  8'h82, 1, 0,  1, 0, 1, 2, 0, 0};
        vecs[7]  = '{15, 8'h00, 1, 0,  1, 0, 1, 2, 0, 0};
        vecs[8]  = '{8,  8'h28, 1, 0,  0, 0, 0, 0, 1, 1};
        vecs[9]  = '{15, 8'h07, 1, 0,  0, 0, 0, 0, 1, 1};
        vecs[10] = '{8,  8'hEA, 1, 0,  1, 1, 1, 3, 1, 1};
        vecs[11] = '{8,  8'h00, 1, 1,  1, 1, 1, 3, 1, 1};
        vecs[12] = '{8,  8'h00, 0, 0,  1, 1, 1, 3, 1, 1};
        vecs[13] = '{9,  8'h00, 1, 0,  1, 1, 1, 3, 1, 1};
        vecs[14] = '{8,  8'h08, 1, 0,  0, 0, 0, 0, 1, 0};

        reset_l = 1'b0; bus_a = '0; bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_aen = 1'b0;
        bus_d = '0; hercules_hw = 1'b1; crtc_dout = '0; vsync = 1'b0; hsync_in = 1'b0;
        video = 1'b0; lpen_strobe = 1'b0;
        @(negedge clk);
        do_reset();
        check_all();

        // Status read-back and CRTC data pass-through
        hsync_in = 1'b1; video = 1'b1;
        set_vsync(1'b1);
        check_read(BASE + 15'd10, 1'b1, 1'b0, 1'b0);
        bus_a = BASE + 15'd10; bus_ior_l = 1'b0; #1;
        chk("status_79", int'(d1_bus_out), 8'h79);
        chk("status_dir", int'(d1_bus_dir), 1);
        bus_ior_l = 1'b1;
        crtc_dout = 8'hA5;
        check_read(BASE + 15'd1, 1'b1, 1'b0, 1'b0);
        check_read(BASE + 15'd2, 1'b1, 1'b0, 1'b0);
        check_read(BASE + 15'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_vsync(1'b0);
        check_all();

        for (int i = 0; i < 15; i++) begin
            io_write(BASE + 15'(vecs[i].ofs), 8'(vecs[i].d), vecs[i].hw[0], vecs[i].aen[0]);
            chk($sformatf("vec%0d_mode1", i), int'(d1_grph_mode), vecs[i].mode1);
            chk($sformatf("vec%0d_page1", i), int'(d1_grph_page), vecs[i].page1);
            chk($sformatf("vec%0d_mode2", i), int'(d2_grph_mode), vecs[i].mode2);
            chk($sformatf("vec%0d_page2", i), int'(d2_grph_page), vecs[i].page2);
            chk($sformatf("vec%0d_ven", i), int'(d1_ven), vecs[i].ven);
            chk($sformatf("vec%0d_ben", i), int'(d1_ben), vecs[i].ben);
        end

        // Strobe held low for 20 clocks: one update, landing on the third clock
        bus_a = BASE + 15'd8; bus_d = 8'h00; bus_iow_l = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ven_c%0d", i), int'(d1_ven), (i >= 3) ? 0 : 1);
            if (i == 3) bus_d = 8'h08;
        end
        bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        model_write(BASE + 15'd8, 8'h00, 1'b1, 1'b0);
        check_all();

        // Light pen: set, clear, then set and clear in the same cycle
        status_bit("lpen_idle", 0);
        lpen_strobe = 1'b1;
        repeat (2) @(negedge clk);
        status_bit("lpen_early", 0);
        @(negedge clk);
        status_bit("lpen_set", 1);
        m_lpen = 1;
        @(negedge clk);
        io_write(BASE + 15'd11, 8'h00, 1'b1, 1'b0);
        status_bit("lpen_clr", 0);
        lpen_strobe = 1'b0;
        repeat (3) @(negedge clk);
        bus_a = BASE + 15'd11; bus_iow_l = 1'b0; lpen_strobe = 1'b1;
        repeat (4) @(negedge clk);
        bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        m_lpen = 1;
        status_bit("lpen_set_wins", 1);
        lpen_strobe = 1'b0;
        repeat (3) @(negedge clk);

        // Blink divider: 16 frames from a clean start
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            set_vsync(1'b1);
            set_vsync(1'b0);
            chk($sformatf("cursor_p%0d", p), int'(d1_cur), (p >= 8 && p < 16) ? 1 : 0);
            chk($sformatf("char_p%0d", p), int'(d1_chr), (p >= 16) ? 1 : 0);
        end
        check_all();

        // Randomised traffic against the model
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                case ($urandom_range(0, 4))
                    0: ofs = 8;
                    1: ofs = 15;
                    2: ofs = 11;
                    default: ofs = $urandom_range(0, 15);
                endcase
                a = ($urandom_range(0, 9) == 0) ? 15'($urandom) : BASE + 15'(ofs);
                io_write(a, 8'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
            end else if (op <= 6) begin
                video = 1'($urandom); hsync_in = 1'($urandom); crtc_dout = 8'($urandom);
                a = ($urandom_range(0, 7) == 0) ? 15'($urandom) : BASE + 15'($urandom_range(0, 15));
                check_read(a, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 1'($urandom));
                @(negedge clk);
            end else begin
                set_vsync(~vsync);
            end
            check_all();
        end

        // Reset mid-frame with a write strobe in flight
        set_vsync(1'b0);
        do_reset();
        io_write(BASE + 15'd15, 8'h03, 1'b1, 1'b0);
        io_write(BASE + 15'd8, 8'h82, 1'b1, 1'b0);
        for (int p = 0; p < 8; p++) begin
            set_vsync(1'b1);
            set_vsync(1'b0);
        end
        lpen_strobe = 1'b1;
        repeat (4) @(negedge clk);
        lpen_strobe = 1'b0;
        m_lpen = 1;
        set_vsync(1'b1);
        check_all();
        bus_a = BASE + 15'd8; bus_d = 8'h00; bus_iow_l = 1'b0;
        @(negedge clk);
        #2 reset_l = 1'b0;
        #1;
        chk("rst_mode1", int'(d1_grph_mode), 0);
        chk("rst_page1", int'(d1_grph_page), 0);
        chk("rst_page2", int'(d2_grph_page), 0);
        chk("rst_ven", int'(d1_ven), 1);
        chk("rst_ben", int'(d1_ben), 1);
        chk("rst_cursor", int'(d1_cur), 0);
        chk("rst_char", int'(d1_chr), 0);
        bus_a = BASE + 15'd10; #1;
        chk("rst_lpen", int'(d1_bus_out[1]), 0);
        bus_a = BASE + 15'd8;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        m_cfg1 = 0; m_cfg2 = 0; m_mode1 = 0; m_page1 = 0; m_mode2 = 0; m_page2 = 0;
        m_ven = 1; m_ben = 1; m_lpen = 0; m_edges = 1;
        repeat (8) @(negedge clk);
        check_all();
        bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        io_write(BASE + 15'd8, 8'h00, 1'b1, 1'b0);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
